// File: rtl/spike_rate_decoder.sv
// Spike-rate readout: counts spikes per output channel over a programmable window,
// then runs a sequential argmax and presents class/count/tie on a valid/ready port.
module spike_rate_decoder #(
    parameter int unsigned N_OUTPUT     = 3,
    parameter int unsigned COUNT_WIDTH  = 8,
    parameter int unsigned WINDOW_WIDTH = 8,
    parameter int unsigned CLASS_WIDTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WINDOW_WIDTH-1:0] window_len,
    input  logic [N_OUTPUT-1:0]     spikes_in,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [CLASS_WIDTH-1:0]  result_class,
    output logic [COUNT_WIDTH-1:0]  result_count,
    output logic                    result_tie
);

    typedef enum logic [1:0] {StIdle, StCount, StArgmax, StHold} state_e;

    state_e                  state_q, state_d;
    logic [WINDOW_WIDTH-1:0] win_q, win_d;
    logic [COUNT_WIDTH-1:0]  cnt_q [N_OUTPUT];
    logic [COUNT_WIDTH-1:0]  cnt_d [N_OUTPUT];
    logic [CLASS_WIDTH-1:0]  idx_q, idx_d;
    logic [CLASS_WIDTH-1:0]  best_idx_q, best_idx_d;
    logic [COUNT_WIDTH-1:0]  best_cnt_q, best_cnt_d;
    logic                    tie_q, tie_d;
    logic [CLASS_WIDTH-1:0]  res_class_q, res_class_d;
    logic [COUNT_WIDTH-1:0]  res_count_q, res_count_d;
    logic                    res_tie_q, res_tie_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic [COUNT_WIDTH-1:0]  cur_cnt;

    // Channel currently visited by the argmax scan.
    always_comb begin
        cur_cnt = '0;
        for (int unsigned i = 0; i < N_OUTPUT; i++) begin
            if (idx_q == CLASS_WIDTH'(i)) begin
                cur_cnt = cnt_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        best_idx_d  = best_idx_q;
        best_cnt_d  = best_cnt_q;
        tie_d       = tie_q;
        res_class_d = res_class_q;
        res_count_d = res_count_q;
        res_tie_d   = res_tie_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    win_d = window_len;
                    idx_d = '0;
                    for (int unsigned i = 0; i < N_OUTPUT; i++) begin
                        cnt_d[i] = '0;
                    end
                    state_d = (window_len != '0) ? StCount : StArgmax;
                end
            end
            StCount: begin
                for (int unsigned i = 0; i < N_OUTPUT; i++) begin
                    if (spikes_in[i] && (cnt_q[i] != '1)) begin
                        cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
                    end
                end
                win_d = win_q - WINDOW_WIDTH'(1);
                if (win_q == WINDOW_WIDTH'(1)) begin
                    state_d = StArgmax;
                end
            end
            StArgmax: begin
                if (idx_q == '0) begin
                    best_idx_d = '0;
                    best_cnt_d = cur_cnt;
                    tie_d      = 1'b0;
                end else if (cur_cnt > best_cnt_q) begin
                    best_idx_d = idx_q;
                    best_cnt_d = cur_cnt;
                    tie_d      = 1'b0;
                end else if (cur_cnt == best_cnt_q) begin
                    tie_d = 1'b1;
                end
                idx_d = idx_q + CLASS_WIDTH'(1);
                if (idx_q == CLASS_WIDTH'(N_OUTPUT - 1)) begin
                    // Publish the final comparison result directly into the output registers.
                    idx_d       = '0;
                    res_class_d = best_idx_d;
                    res_count_d = best_cnt_d;
                    res_tie_d   = tie_d;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d  = (state_d != StIdle);
        valid_d = (state_d == StHold);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            win_q       <= '0;
            cnt_q       <= '{default: '0};
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_cnt_q  <= '0;
            tie_q       <= 1'b0;
            res_class_q <= '0;
            res_count_q <= '0;
            res_tie_q   <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            best_idx_q  <= best_idx_d;
            best_cnt_q  <= best_cnt_d;
            tie_q       <= tie_d;
            res_class_q <= res_class_d;
            res_count_q <= res_count_d;
            res_tie_q   <= res_tie_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result_class = res_class_q;
    assign result_count = res_count_q;
    assign result_tie   = res_tie_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed and randomized checks of spike_rate_decoder against a count/argmax reference model.
module tb_spike_rate_decoder;

    localparam int N   = 3;
    localparam int CW  = 4;
    localparam int WW  = 8;
    localparam int CLW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic [N-1:0]  spikes_in = '0;
    logic          result_ready = 1'b0;
    logic          busy;
    logic          result_valid;
    logic [CLW-1:0] result_class;
    logic [CW-1:0] result_count;
    logic          result_tie;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] pat[$];
    int exp_class, exp_count, exp_tie;

    spike_rate_decoder #(
        .N_OUTPUT    (N),
        .COUNT_WIDTH (CW),
        .WINDOW_WIDTH(WW),
        .CLASS_WIDTH (CLW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .window_len  (window_len),
        .spikes_in   (spikes_in),
        .busy        (busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_class(result_class),
        .result_count(result_count),
        .result_tie  (result_tie)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: saturating per-channel totals, lowest index among the maxima, tie if shared.
    task automatic model(input int w);
        int cnt[N];
        int best;
        int n_best;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int k = 0; k < w; k++)
            for (int i = 0; i < N; i++)
                if (pat[k][i]) cnt[i]++;
        best = 0;
        for (int i = 0; i < N; i++) begin
            if (cnt[i] > (2 ** CW) - 1) cnt[i] = (2 ** CW) - 1;
            if (cnt[i] > best) best = cnt[i];
        end
        exp_class = -1;
        n_best = 0;
        for (int i = 0; i < N; i++) begin
            if (cnt[i] == best) begin
                n_best++;
                if (exp_class < 0) exp_class = i;
            end
        end
        exp_count = best;
        exp_tie   = (n_best > 1) ? 1 : 0;
    endtask

    task automatic check_result(input string tag);
        chk({tag, " valid"}, {31'd0, result_valid}, 1);
        chk({tag, " class"}, {30'd0, result_class}, exp_class);
        chk({tag, " count"}, {28'd0, result_count}, exp_count);
        chk({tag, " tie"}, {31'd0, result_tie}, exp_tie);
    endtask

    task automatic run(input string tag, input int w);
        model(w);
        window_len = WW'(w);
        start = 1'b1;
        step();
        start = 1'b0;
        window_len = WW'($urandom);
        chk({tag, " busy_rise"}, {31'd0, busy}, 1);
        for (int k = 0; k < w; k++) begin
            spikes_in = pat[k];
            step();
        end
        spikes_in = N'($urandom);
        for (int k = 0; k < N - 1; k++) step();
        chk({tag, " valid_early"}, {31'd0, result_valid}, 0);
        step();
        spikes_in = N'($urandom);
        check_result(tag);
    endtask

    task automatic handshake(input string tag);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk({tag, " valid_drop"}, {31'd0, result_valid}, 0);
        chk({tag, " busy_drop"}, {31'd0, busy}, 0);
    endtask

    initial begin
        #2;
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset valid", {31'd0, result_valid}, 0);
        chk("reset class", {30'd0, result_class}, 0);
        chk("reset count", {28'd0, result_count}, 0);
        chk("reset tie", {31'd0, result_tie}, 0);
        step();
        step();
        rst = 1'b1;
        step();

        // Single winner: ch1 every cycle for 10 cycles.
        pat.delete();
        for (int k = 0; k < 10; k++) pat.push_back(3'b010);
        run("single", 10);
        handshake("single");

        // Tie between ch0 and ch2 at 4, ch1 at 2.
        pat = '{3'b111, 3'b111, 3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000};
        run("tie", 8);
        handshake("tie");
        pat = '{3'b111, 3'b111, 3'b101, 3'b101, 3'b100, 3'b000, 3'b000, 3'b000};
        run("tie_break", 8);
        handshake("tie_break");

        // Saturation at 15 on ch2.
        pat.delete();
        for (int k = 0; k < 20; k++) pat.push_back(3'b100);
        run("sat", 20);
        handshake("sat");

        // Asynchronous reset partway through a 50-cycle window.
        window_len = 8'd50;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            spikes_in = N'($urandom);
            step();
        end
        #3 rst = 1'b0;
        #1;
        chk("midrst busy", {31'd0, busy}, 0);
        chk("midrst valid", {31'd0, result_valid}, 0);
        chk("midrst class", {30'd0, result_class}, 0);
        chk("midrst count", {28'd0, result_count}, 0);
        chk("midrst tie", {31'd0, result_tie}, 0);
        #2 rst = 1'b1;
        step();
        pat = '{3'b011, 3'b010, 3'b011, 3'b010, 3'b010};
        run("post_rst", 5);
        handshake("post_rst");

        // Backpressure with ignored start pulses, then start coinciding with the handshake.
        pat = '{3'b001, 3'b101, 3'b001, 3'b100};
        run("bp", 4);
        for (int c = 0; c < 5; c++) begin
            start = (c % 2 == 0);
            window_len = WW'($urandom_range(1, 9));
            step();
            start = 1'b0;
            chk("bp busy_hold", {31'd0, busy}, 1);
            check_result("bp hold");
        end
        start = 1'b1;
        result_ready = 1'b1;
        step();
        start = 1'b0;
        result_ready = 1'b0;
        chk("bp valid_drop", {31'd0, result_valid}, 0);
        chk("bp busy_drop", {31'd0, busy}, 0);
        step();
        chk("bp start_not_queued", {31'd0, busy}, 0);
        pat = '{3'b010, 3'b110, 3'b100};
        run("bp_next", 3);
        handshake("bp_next");

        // Zero-length window.
        pat.delete();
        run("zero", 0);
        handshake("zero");

        // Randomized decodes with random backpressure.
        for (int r = 0; r < 10; r++) begin
            int w;
            w = $urandom_range(0, 30);
            pat.delete();
            for (int k = 0; k < w; k++) pat.push_back(N'($urandom));
            run("rand", w);
            repeat ($urandom_range(0, 3)) begin
                step();
                check_result("rand hold");
            end
            handshake("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
